// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    // Scan N positions starting at ptr; the first active request wins.
    always_comb begin
        logic [IW:0] pos;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        pos       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = (IW+1)'(ptr) + (IW+1)'(i);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!gnt_valid && req[pos[IW-1:0]]) begin
                gnt_valid           = 1'b1;
                gnt_idx             = pos[IW-1:0];
                gnt[pos[IW-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters with round-robin
// arbitration, IDLE->SETUP->ACCESS sequencing and an ACCESS watchdog.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_slverr,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pslverr
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    apb_state_e          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    cur_idx;
    logic [NUM_REQ-1:0]  cur_gnt;
    logic [CNT_W-1:0]    wait_cnt;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_valid;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // Accept handshake is only offered while the bus is free.
    assign req_ready = (state == IDLE) ? arb_gnt : '0;

    // APB sequencer, wait counter, round-robin pointer and response registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_idx    <= '0;
            cur_gnt    <= '0;
            wait_cnt   <= '0;
            paddr      <= '0;
            pwdata     <= '0;
            pwrite     <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        paddr   <= req_addr[arb_idx*ADDR_W +: ADDR_W];
                        pwdata  <= req_wdata[arb_idx*DATA_W +: DATA_W];
                        pwrite  <= req_write[arb_idx];
                        cur_idx <= arb_idx;
                        cur_gnt <= arb_gnt;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (pready || (wait_cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= cur_gnt;
                        rr_ptr    <= (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + 1'b1;
                        state     <= IDLE;
                        if (pready) begin
                            rsp_rdata  <= pwrite ? '0 : prdata;
                            rsp_slverr <= pslverr;
                        end else begin
                            rsp_rdata  <= '0;
                            rsp_slverr <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: one task per scenario.
module tb_apb_master_arbiter;
    import apb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic              pclk = 1'b0;
    logic              preset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_slverr;
    logic [AW-1:0]     paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DW-1:0]     pwdata;
    logic              pready;
    logic [DW-1:0]     prdata;
    logic              pslverr;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          order_q[$];
    int          gcyc_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          slave_wait = 0;
    logic [DW-1:0] slave_rdata = '0;
    logic        slave_err = 1'b0;
    int          acc_cnt = 0;
    int          access_cycles = 0;

    apb_master_arbiter #(
        .NUM_REQ     (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .paddr      (paddr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr)
    );

    always #5 pclk = ~pclk;

    // Slave model: ready after slave_wait wait states in ACCESS.
    assign pready  = psel && penable && (acc_cnt >= slave_wait);
    assign prdata  = slave_rdata;
    assign pslverr = slave_err & pready;

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    // Response monitor: pop scoreboard on every rsp_valid pulse.
    always @(negedge pclk) begin
        rsp_t got;
        rsp_t e;
        if (psel && penable) access_cycles++;
        if (rsp_valid !== '0) begin
            got = {rsp_valid, rsp_rdata, rsp_slverr};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected got=%h", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL rsp_scoreboard got=%h expected=%h", got, e);
                end
            end
        end
    end

    function automatic rsp_t model_rsp(input int idx, input logic wr);
        rsp_t r;
        r.gnt      = '0;
        r.gnt[idx] = 1'b1;
        if (slave_wait >= int'(TO)) begin
            r.rdata = '0;
            r.err   = 1'b1;
        end else begin
            r.rdata = wr ? '0 : slave_rdata;
            r.err   = slave_err;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Present one request, wait for acceptance, optionally score the response.
    task automatic issue(input int idx, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input bit push);
        int cyc;
        bit ok;
        req_valid[idx]           = 1'b1;
        req_write[idx]           = wr;
        req_addr[idx*AW +: AW]   = addr;
        req_wdata[idx*DW +: DW]  = wd;
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < 100) begin
            @(negedge pclk);
            if (req_ready[idx]) ok = 1'b1;
            else cyc++;
        end
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL grant_timeout req=%0d got=0 expected=1", idx);
        end else if (push) begin
            exp_q.push_back(model_rsp(idx, wr));
        end
        tick();
        req_valid[idx] = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(negedge pclk);
            cyc++;
        end
        tick();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        tick();
        tick();
        vectors++;
        if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rsp=%b rdata=%h err=%b expected all 0",
                     psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr);
        end
        vectors++;
        if (req_ready !== '0) begin
            miscompares++;
            $display("FAIL reset_req_ready got=%b expected=0000", req_ready);
        end
        preset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        slave_wait = 1000;
        issue(0, 1'b0, 32'h0000_0080, '0, 1'b0);
        tick();
        vectors++;
        if ({psel, penable} !== 2'b11) begin
            miscompares++;
            $display("FAIL abort_in_access got=%b expected=11", {psel, penable});
        end
        preset = 1'b1;
        tick();
        preset = 1'b0;
        vectors++;
        if ({psel, penable, rsp_valid} !== '0) begin
            miscompares++;
            $display("FAIL abort_after_reset psel=%b pen=%b rsp=%b expected 0", psel, penable, rsp_valid);
        end
        repeat (3) tick();
        slave_wait  = 0;
        slave_rdata = 32'h0BAD_F00D;
        issue(1, 1'b0, 32'h0000_0100, '0, 1'b1);
        drain();
    endtask

    task automatic test_single_write();
        slave_wait = 0;
        slave_err  = 1'b0;
        req_valid[0]         = 1'b1;
        req_write[0]         = 1'b1;
        req_addr[0 +: AW]    = 32'h0000_0010;
        req_wdata[0 +: DW]   = 32'hA5A5_A5A5;
        @(negedge pclk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL wr_req_ready got=%b expected=0001", req_ready);
        end
        exp_q.push_back(model_rsp(0, 1'b1));
        tick();
        req_valid[0] = 1'b0;
        vectors++;
        if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 32'h0000_0010, 32'hA5A5_A5A5}) begin
            miscompares++;
            $display("FAIL wr_setup psel=%b pen=%b pwr=%b paddr=%h pwdata=%h expected 1 0 1 00000010 a5a5a5a5",
                     psel, penable, pwrite, paddr, pwdata);
        end
        tick();
        vectors++;
        if ({psel, penable} !== 2'b11) begin
            miscompares++;
            $display("FAIL wr_access got=%b expected=11", {psel, penable});
        end
        tick();
        vectors++;
        if ({psel, penable, rsp_valid, rsp_slverr} !== {2'b00, 4'b0001, 1'b0}) begin
            miscompares++;
            $display("FAIL wr_rsp psel=%b pen=%b rsp=%b err=%b expected 0 0 0001 0",
                     psel, penable, rsp_valid, rsp_slverr);
        end
        drain();
    endtask

    task automatic test_read_wait();
        slave_wait  = 3;
        slave_rdata = 32'hDEAD_BEEF;
        issue(2, 1'b0, 32'h2000_0040, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({psel, penable, pwrite, paddr} !== {3'b110, 32'h2000_0040}) begin
                miscompares++;
                $display("FAIL rd_hold cyc=%0d psel=%b pen=%b pwr=%b paddr=%h expected 1 1 0 20000040",
                         i, psel, penable, pwrite, paddr);
            end
        end
        tick();
        vectors++;
        if ({rsp_valid, rsp_rdata} !== {4'b0100, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL rd_rsp rsp=%b rdata=%h expected 0100 deadbeef", rsp_valid, rsp_rdata);
        end
        drain();
    endtask

    // Raise all requesters in mask at once and log grant order and cycle.
    task automatic grant_batch(input logic [N-1:0] mask);
        logic [N-1:0] pend;
        logic [N-1:0] hit;
        int cyc;
        int g;
        order_q.delete();
        gcyc_q.delete();
        pend = mask;
        for (int i = 0; i < int'(N); i++) begin
            if (mask[i]) begin
                req_valid[i]          = 1'b1;
                req_write[i]          = 1'b0;
                req_addr[i*AW +: AW]  = AW'(32'h0000_0100 + i * 4);
            end
        end
        cyc = 0;
        while (pend != '0 && cyc < 300) begin
            @(negedge pclk);
            cyc++;
            hit = req_ready & pend;
            if (hit != '0) begin
                g = 0;
                for (int i = int'(N) - 1; i >= 0; i--) if (hit[i]) g = i;
                order_q.push_back(g);
                gcyc_q.push_back(cyc);
                exp_q.push_back(model_rsp(g, 1'b0));
                pend[g] = 1'b0;
                tick();
                req_valid[g] = 1'b0;
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_a[4];
        int exp_b[2];
        exp_a = '{0, 1, 2, 3};
        exp_b = '{1, 3};
        preset = 1'b1;
        tick();
        preset = 1'b0;
        slave_wait  = 0;
        slave_rdata = 32'h1357_9BDF;
        grant_batch(4'b1111);
        vectors++;
        if (order_q.size() !== 4) begin
            miscompares++;
            $display("FAIL rr_all_count got=%0d expected=4", order_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (order_q[i] !== exp_a[i]) begin
                    miscompares++;
                    $display("FAIL rr_all_order slot=%0d got=%0d expected=%0d", i, order_q[i], exp_a[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (gcyc_q[i] - gcyc_q[i-1] !== 3) begin
                    miscompares++;
                    $display("FAIL back_to_back_gap slot=%0d got=%0d expected=3", i, gcyc_q[i] - gcyc_q[i-1]);
                end
            end
        end
        drain();
        grant_batch(4'b1010);
        vectors++;
        if (order_q.size() !== 2) begin
            miscompares++;
            $display("FAIL rr_13_count got=%0d expected=2", order_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (order_q[i] !== exp_b[i]) begin
                    miscompares++;
                    $display("FAIL rr_13_order slot=%0d got=%0d expected=%0d", i, order_q[i], exp_b[i]);
                end
            end
        end
        drain();
    endtask

    task automatic test_timeout();
        int cyc;
        slave_wait    = 1000;
        slave_rdata   = 32'h1234_5678;
        issue(1, 1'b0, 32'h0000_0200, '0, 1'b1);
        access_cycles = 0;
        tick();
        cyc = 0;
        while (psel && cyc < 40) begin
            tick();
            cyc++;
        end
        vectors++;
        if (access_cycles !== int'(TO)) begin
            miscompares++;
            $display("FAIL timeout_access_cycles got=%0d expected=%0d", access_cycles, TO);
        end
        vectors++;
        if ({psel, rsp_valid, rsp_rdata, rsp_slverr} !== {1'b0, 4'b0010, 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL timeout_rsp psel=%b rsp=%b rdata=%h err=%b expected 0 0010 00000000 1",
                     psel, rsp_valid, rsp_rdata, rsp_slverr);
        end
        slave_wait = 0;
        drain();
    endtask

    task automatic test_slverr();
        slave_wait  = 0;
        slave_err   = 1'b1;
        slave_rdata = 32'hCAFE_0001;
        issue(3, 1'b0, 32'h0000_0300, '0, 1'b1);
        drain();
        slave_err   = 1'b0;
        slave_rdata = 32'hCAFE_0002;
        issue(3, 1'b0, 32'h0000_0304, '0, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        slave_wait  = 0;
        slave_rdata = 32'h0F0F_0F0F;
        issue(2, 1'b1, 32'h0000_0400, 32'h1111_2222, 1'b1);
        issue(2, 1'b0, 32'h0000_0404, '0, 1'b1);
        issue(2, 1'b1, 32'h0000_0408, 32'h3333_4444, 1'b1);
        drain();
    endtask

    initial begin
        preset    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        test_reset();
        test_reset_mid_access();
        test_single_write();
        test_read_wait();
        test_round_robin();
        test_timeout();
        test_slverr();
        test_back_to_back();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL final_queue pending=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
